// File: rtl/timer_pkg.sv
// Shared types and constants for the chess-clock minute countdown.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } timer_state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t DIGIT_MAX_UNITS = 4'd9;
   localparam bcd_t DIGIT_MAX_TENS  = 4'd5;

   function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> max_val and raises borrow on that step.
module bcd_down_digit
   import timer_pkg::*;
(
   input  logic clk_sys,
   input  logic rst_n,
   input  logic load,
   input  bcd_t load_val,
   input  logic dec,
   input  bcd_t max_val,
   output bcd_t count,
   output logic borrow
);

   bcd_t count_q;
   bcd_t count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec) begin
         count_d = (count_q == 4'd0) ? max_val : count_q - 4'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign borrow = dec && !load && (count_q == 4'd0);

endmodule

// File: rtl/minute_countdown.sv
// Per-player MM:SS countdown with preset load, run control and flag-fall.
// Optional low-time WARN output is built only when TIMER_WARN_EN is defined.
//
// state   | meaning
// IDLE    | loaded or paused, digits hold
// RUN     | counting down one second per TICK
// EXPIRED | reached 00:00, flag fallen; left only by LOAD or CLR
module minute_countdown
   import timer_pkg::*;
#(
   parameter logic [5:0] PRESET_MAX = 6'd59
`ifdef TIMER_WARN_EN
   ,
   parameter logic [6:0] WARN_SEC   = 7'd10
`endif
)
(
   input  logic       CLK,
   input  logic       CLR,
   input  logic       LOAD,
   input  logic [3:0] PRESET_TENS,
   input  logic [3:0] PRESET_UNITS,
   input  logic       CE,
   input  logic       TICK,
   output logic [3:0] MIN_TENS,
   output logic [3:0] MIN_UNITS,
   output logic [3:0] SEC_TENS,
   output logic [3:0] SEC_UNITS,
   output logic       RUNNING,
   output logic       FLAG,
   output logic       WARN
);

   localparam bcd_t MAX_TENS  = bcd_t'(PRESET_MAX / 6'd10);
   localparam bcd_t MAX_UNITS = bcd_t'(PRESET_MAX % 6'd10);

   timer_state_e state_q, state_d;

   bcd_t        tens_clamped, units_clamped;
   bcd_t        load_tens, load_units;
   logic [5:0]  preset_total;
   logic        load_zero;
   logic        time_zero, time_one;
   logic        dec_en;
   logic        borrow_su, borrow_st, borrow_mu, borrow_mt;

   // Digit clamp first, then limit the combined minutes to PRESET_MAX.
   always_comb begin
      tens_clamped  = clamp_digit(PRESET_TENS, DIGIT_MAX_TENS);
      units_clamped = clamp_digit(PRESET_UNITS, DIGIT_MAX_UNITS);
      preset_total  = 6'(tens_clamped) * 6'd10 + 6'(units_clamped);
      load_tens     = tens_clamped;
      load_units    = units_clamped;
      if (preset_total > PRESET_MAX) begin
         load_tens  = MAX_TENS;
         load_units = MAX_UNITS;
      end
      load_zero = (load_tens == 4'd0) && (load_units == 4'd0);
   end

   assign time_zero = (MIN_TENS == 4'd0) && (MIN_UNITS == 4'd0) &&
                      (SEC_TENS == 4'd0) && (SEC_UNITS == 4'd0);
   assign time_one  = (MIN_TENS == 4'd0) && (MIN_UNITS == 4'd0) &&
                      (SEC_TENS == 4'd0) && (SEC_UNITS == 4'd1);
   assign dec_en    = (state_q == RUN) && TICK && !LOAD && !time_zero;

   bcd_down_digit u_sec_units (
      .clk_sys  (CLK),
      .rst_n    (CLR),
      .load     (LOAD),
      .load_val (4'd0),
      .dec      (dec_en),
      .max_val  (DIGIT_MAX_UNITS),
      .count    (SEC_UNITS),
      .borrow   (borrow_su)
   );

   bcd_down_digit u_sec_tens (
      .clk_sys  (CLK),
      .rst_n    (CLR),
      .load     (LOAD),
      .load_val (4'd0),
      .dec      (borrow_su),
      .max_val  (DIGIT_MAX_TENS),
      .count    (SEC_TENS),
      .borrow   (borrow_st)
   );

   bcd_down_digit u_min_units (
      .clk_sys  (CLK),
      .rst_n    (CLR),
      .load     (LOAD),
      .load_val (load_units),
      .dec      (borrow_st),
      .max_val  (DIGIT_MAX_UNITS),
      .count    (MIN_UNITS),
      .borrow   (borrow_mu)
   );

   bcd_down_digit u_min_tens (
      .clk_sys  (CLK),
      .rst_n    (CLR),
      .load     (LOAD),
      .load_val (load_tens),
      .dec      (borrow_mu),
      .max_val  (DIGIT_MAX_TENS),
      .count    (MIN_TENS),
      .borrow   (borrow_mt)
   );

   // borrow_mt would mean an underflow past 00:00; treat it as flag-fall.
   always_comb begin
      state_d = state_q;
      if (LOAD) begin
         state_d = load_zero ? EXPIRED : IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (CE && !time_zero) state_d = RUN;
            end
            RUN: begin
               if ((TICK && time_one) || borrow_mt) state_d = EXPIRED;
               else if (!CE)                        state_d = IDLE;
            end
            EXPIRED: state_d = EXPIRED;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign RUNNING = (state_q == RUN);
   assign FLAG    = (state_q == EXPIRED);

`ifdef TIMER_WARN_EN
   logic [11:0] total_now, total_next;
   logic        warn_q, warn_d;

   // Compare against the value the digits take on this edge so WARN lines up with them.
   always_comb begin
      total_now = 12'(MIN_TENS) * 12'd600 + 12'(MIN_UNITS) * 12'd60 +
                  12'(SEC_TENS) * 12'd10 + 12'(SEC_UNITS);
      if (LOAD) begin
         total_next = 12'(load_tens) * 12'd600 + 12'(load_units) * 12'd60;
      end else if (dec_en) begin
         total_next = total_now - 12'd1;
      end else begin
         total_next = total_now;
      end
      warn_d = (total_next != 12'd0) && (total_next <= 12'(WARN_SEC));
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_d;
      end
   end

   assign WARN = warn_q;
`else
   assign WARN = 1'b0;
`endif

endmodule
